// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - controller <-> datapath control bundle
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegDst;
  logic       RegWrite;

  // master: the control FSM
  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           PCSource, ALUOp, ALUSrcA, ALUSrcB, RegDst, RegWrite
  );

  // slave: the datapath it steers
  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           PCSource, ALUOp, ALUSrcA, ALUSrcB, RegDst, RegWrite
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS main control FSM
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_multicycle_ctrl_if.master bus,
  output logic                 illegal_op,
  output logic [3:0]           state,
  output logic [CNT_W-1:0]     instr_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB    = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
    TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       fetch;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regdst;
    logic       regwrite;
    logic       illegal;
  } ctl_t;

  function automatic state_e next_state(state_e s, logic [5:0] op, logic rdy);
    state_e n;
    n = TRAP;
    case (s)
      FETCH:  n = rdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: n = MEMADR;
          OP_RTYPE:     n = EXEC;
          OP_BEQ:       n = BRANCH;
          OP_J:         n = JUMP;
          OP_ADDI:      n = ADDIEX;
          default:      n = TRAP;
        endcase
      end
      MEMADR: n = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  n = rdy ? MEMWB : MEMRD;
      MEMWB:  n = FETCH;
      MEMWR:  n = rdy ? FETCH : MEMWR;
      EXEC:   n = RWB;
      RWB:    n = FETCH;
      BRANCH: n = FETCH;
      JUMP:   n = FETCH;
      ADDIEX: n = ADDIWB;
      ADDIWB: n = FETCH;
      default: n = TRAP;
    endcase
    return n;
  endfunction

  function automatic ctl_t decode(state_e s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.fetch = 1'b1; c.memread = 1'b1; c.alusrcb = 2'b01; end
      DECODE: c.alusrcb = 2'b11;
      MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:  begin c.memread = 1'b1; c.iord = 1'b1; end
      MEMWB:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:  begin c.memwrite = 1'b1; c.iord = 1'b1; end
      EXEC:   begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      RWB:    begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BRANCH: begin
        c.alusrca = 1'b1; c.aluop = 2'b01;
        c.pcwritecond = 1'b1; c.pcsource = 2'b01;
      end
      JUMP:   begin c.pcwrite = 1'b1; c.pcsource = 2'b10; end
      ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ADDIWB: c.regwrite = 1'b1;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  state_e state_q;
  state_e nxt;
  ctl_t   ctl_q;

  always_comb nxt = next_state(state_q, bus.opcode, bus.mem_ready);

  // Controls are decoded from the next state so they are registered with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      ctl_q       <= decode(FETCH);
      instr_count <= '0;
    end else begin
      state_q <= nxt;
      ctl_q   <= decode(nxt);
      if (nxt == FETCH && state_q != FETCH)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  // PC/IR load only on the fetch cycle that actually completes
  assign bus.PCWrite     = ctl_q.pcwrite | (ctl_q.fetch & bus.mem_ready);
  assign bus.IRWrite     = ctl_q.fetch & bus.mem_ready;
  assign bus.PCWriteCond = ctl_q.pcwritecond;
  assign bus.IorD        = ctl_q.iord;
  assign bus.MemRead     = ctl_q.memread;
  assign bus.MemWrite    = ctl_q.memwrite;
  assign bus.MemtoReg    = ctl_q.memtoreg;
  assign bus.PCSource    = ctl_q.pcsource;
  assign bus.ALUOp       = ctl_q.aluop;
  assign bus.ALUSrcA     = ctl_q.alusrca;
  assign bus.ALUSrcB     = ctl_q.alusrcb;
  assign bus.RegDst      = ctl_q.regdst;
  assign bus.RegWrite    = ctl_q.regwrite;
  assign illegal_op      = ctl_q.illegal;
  assign state           = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             illegal_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  mips_multicycle_ctrl_if bus();

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .illegal_op  (illegal_op),
    .state       (state),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       st;
    logic [15:0]      ctl;
    logic             ill;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               failures = 0;
  logic [CNT_W-1:0] model_cnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,PCSource,ALUOp,ALUSrcA,ALUSrcB,RegDst,RegWrite}
  function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rdst, rw;
    logic [1:0] pcs, aop, srcb;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rdst, rw} = '0;
    {pcs, aop, srcb} = '0;
    case (st)
      4'd0:  begin pcw = mr; irw = mr; mrd = 1'b1; srcb = 2'b01; end
      4'd1:  srcb = 2'b11;
      4'd2:  begin srca = 1'b1; srcb = 2'b10; end
      4'd3:  begin mrd = 1'b1; iord = 1'b1; end
      4'd4:  begin m2r = 1'b1; rw = 1'b1; end
      4'd5:  begin mwr = 1'b1; iord = 1'b1; end
      4'd6:  begin srca = 1'b1; aop = 2'b10; end
      4'd7:  begin rdst = 1'b1; rw = 1'b1; end
      4'd8:  begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      4'd9:  begin pcw = 1'b1; pcs = 2'b10; end
      4'd10: begin srca = 1'b1; srcb = 2'b10; end
      4'd11: rw = 1'b1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, srca, srcb, rdst, rw};
  endfunction

  function automatic logic [15:0] dut_ctl();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.MemtoReg, bus.IRWrite, bus.PCSource, bus.ALUOp, bus.ALUSrcA,
            bus.ALUSrcB, bus.RegDst, bus.RegWrite};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("state", 32'(state), 32'(e.st));
      check("ctl", 32'(dut_ctl()), 32'(e.ctl));
      check("illegal_op", 32'(illegal_op), 32'(e.ill));
      check("instr_count", 32'(instr_count), 32'(e.cnt));
      check("rd_wr_excl", 32'(bus.MemRead & bus.MemWrite), 32'd0);
      check("pcw_excl", 32'(bus.PCWrite & bus.PCWriteCond), 32'd0);
    end
  end

  task automatic step(input logic [3:0] st, input logic mr);
    exp_t e;
    bus.mem_ready = mr;
    e.st  = st;
    e.ctl = exp_ctl(st, mr);
    e.ill = (st == 4'd12);
    e.cnt = model_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
    bus.opcode = op;
    for (int i = 0; i < fs; i++) step(4'd0, 1'b0);
    step(4'd0, 1'b1);
    step(4'd1, rnd());
    case (op)
      6'b100011: begin
        step(4'd2, rnd());
        for (int i = 0; i < ms; i++) step(4'd3, 1'b0);
        step(4'd3, 1'b1);
        step(4'd4, rnd());
      end
      6'b101011: begin
        step(4'd2, rnd());
        for (int i = 0; i < ms; i++) step(4'd5, 1'b0);
        step(4'd5, 1'b1);
      end
      6'b000000: begin step(4'd6, rnd()); step(4'd7, rnd()); end
      6'b000100: step(4'd8, rnd());
      6'b000010: step(4'd9, rnd());
      6'b001000: begin step(4'd10, rnd()); step(4'd11, rnd()); end
      default: begin
        for (int i = 0; i < 20; i++) step(4'd12, rnd());
        return;
      end
    endcase
    model_cnt++;
  endtask

  // Pulse rst between clock edges and check the asynchronous effect
  task automatic async_reset(input string tag);
    #5;
    rst = 1'b1;
    #1;
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_cnt"}, 32'(instr_count), 32'd0);
    check({tag, "_memread"}, 32'(bus.MemRead), 32'd1);
    check({tag, "_iord"}, 32'(bus.IorD), 32'd0);
    check({tag, "_pcwrite"}, 32'(bus.PCWrite), 32'(bus.mem_ready));
    check({tag, "_illegal"}, 32'(illegal_op), 32'd0);
    #1;
    rst = 1'b0;
    model_cnt = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.opcode = 6'b000000;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    step(4'd0, 1'b0);
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 3);
    run_instr(6'b000100, 1, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b101011, 2, 1);
    run_instr(6'b001000, 0, 0);
    run_instr(6'b100011, 1, 0);
    step(4'd0, 1'b0);

    bus.opcode = 6'b100011;
    step(4'd0, 1'b1);
    step(4'd1, 1'b1);
    step(4'd2, 1'b1);
    bus.mem_ready = 1'b0;
    begin
      exp_t e;
      e.st = 4'd3; e.ctl = exp_ctl(4'd3, 1'b0); e.ill = 1'b0; e.cnt = model_cnt;
      sb.push_back(e);
    end
    async_reset("rst_memrd");
    step(4'd0, 1'b0);

    run_instr(6'b111111, 0, 0);
    async_reset("rst_trap");
    step(4'd0, 1'b0);

    for (int i = 0; i < 16; i++) run_instr(6'b000000, 0, 0);
    step(4'd0, 1'b0);
    check("wrap", 32'(instr_count), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle variant of the MIPS datapath.
- Sits directly upstream of the ALU control decoder. It drives ALUOp (00 = add, 01 = subtract, 10 = decode funct) plus every datapath mux and write-enable.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Stalls on a memory ready handshake, traps on unsupported opcodes, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  6  instruction bits [31:26] from the instruction register.
- mem_ready  input  1  memory completes the current read/write this cycle.
- PCWrite  output  1  unconditional PC write enable.
- PCWriteCond  output  1  PC write enable qualified by ALU zero (branch).
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- MemtoReg  output  1  register write data select: 1 = MDR, 0 = ALUOut.
- IRWrite  output  1  instruction register load enable.
- PCSource  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUOp  output  2  to ALU control decoder.
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- RegDst  output  1  destination register select: 1 = rd, 0 = rt.
- RegWrite  output  1  register file write enable.
- illegal_op  output  1  high while in TRAP.
- state  output  4  current state encoding (debug).
- instr_count  output  CNT_W  count of retired instructions.

Behaviour:
- Reset: asynchronous, active-high.
  - On rst = 1: state = FETCH (0), instr_count = 0.
  - Outputs are Moore-decoded from state (plus mem_ready where noted). During and after reset they equal the FETCH values: MemRead = 1, ALUSrcB = 01, IorD = 0, ALUSrcA = 0, ALUOp = 00, PCSource = 00, PCWrite = IRWrite = mem_ready, all other outputs 0.
  - Reset mid-instruction abandons the instruction; no counter increment.
- State encoding and outputs. Any output not listed for a state is 0.
  - FETCH = 0: outputs as above. Hold while mem_ready = 0; go to DECODE when mem_ready = 1.
  - DECODE = 1: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00. Next state by opcode:
    - 100011 (lw) or 101011 (sw) → MEMADR.
    - 000000 (R-type) → EXEC.
    - 000100 (beq) → BRANCH.
    - 000010 (j) → JUMP.
    - 001000 (addi) → ADDIEX.
    - any other opcode → TRAP.
  - MEMADR = 2: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next is MEMRD for lw, MEMWR for sw. The opcode is stable from the IR, so it is re-sampled here.
  - MEMRD = 3: MemRead = 1, IorD = 1. Hold until mem_ready, then → MEMWB.
  - MEMWB = 4: RegDst = 0, MemtoReg = 1, RegWrite = 1. → FETCH.
  - MEMWR = 5: MemWrite = 1, IorD = 1. Hold until mem_ready, then → FETCH.
  - EXEC = 6: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. → RWB.
  - RWB = 7: RegDst = 1, MemtoReg = 0, RegWrite = 1. → FETCH.
  - BRANCH = 8: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01. → FETCH.
  - JUMP = 9: PCWrite = 1, PCSource = 10. → FETCH.
  - ADDIEX = 10: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. → ADDIWB.
  - ADDIWB = 11: RegDst = 0, MemtoReg = 0, RegWrite = 1. → FETCH.
  - TRAP = 12: illegal_op = 1, all enables 0. Remains in TRAP until rst.
  - Encodings 13–15: unreachable; treat as TRAP.
- Latency in cycles, with mem_ready tied high:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each cycle mem_ready is low adds one cycle in FETCH, MEMRD or MEMWR.
- Handshake:
  - MemRead/MemWrite stay asserted and address selects stay stable for the whole wait.
  - PCWrite and IRWrite assert only in the FETCH cycle where mem_ready = 1, so exactly one PC update per fetch.
  - mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Counter:
  - instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR (with mem_ready), RWB, BRANCH, JUMP or ADDIWB.
  - Wraps modulo 2^CNT_W.
  - No increment on entry to TRAP or while in TRAP.
- Output integrity: MemRead and MemWrite are never high in the same cycle; at most one of PCWrite and PCWriteCond is high in any cycle.

Test Plan:
- rst pulse mid-MEMRD → state = 0, instr_count = 0, MemRead = 1, IorD = 0 immediately (asynchronous); PCWrite = 0 while mem_ready = 0.
- mem_ready = 1, opcode = 000000 → states 0, 1, 6, 7, 0. ALUOp = 10 in EXEC; RegWrite = 1 and RegDst = 1 in RWB; instr_count 0 → 1.
- lw (100011) with mem_ready low 3 cycles in MEMRD → states 0, 1, 2, 3, 3, 3, 3, 4, 0. MemRead and IorD held for all four MEMRD cycles; MemtoReg = 1 in MEMWB; 8 cycles total.
- beq (000100) → BRANCH with ALUOp = 01, PCWriteCond = 1, PCSource = 01. Then j (000010) → JUMP with PCWrite = 1, PCSource = 10. instr_count = 2.
- opcode = 111111 → DECODE, then TRAP. illegal_op = 1 held for 20 cycles, count unchanged; after rst, state = 0 and illegal_op = 0.
- Preload check with CNT_W = 4: 16 retired R-type instructions → instr_count wraps to 0.
